mem_bus_responder: RTL

Word-addressed responder for the single-cycle CS/WE/ADDR/Mem_Bus protocol issued by the multicycle CPU core. It is the target side of the CPU's memory interface: it serves a 120-word RAM plus a small memory-mapped I/O window with an LED register, synchronized switch input, cycle counter and sticky status. It replaces the plain RAM model in the top-level `Complete_MIPS` integration.

---
 rtl/mem_bus_pkg.sv | 29 ++
 rtl/mem_bus_responder_mmio_regs.sv | 117 +++++++++++
 rtl/mem_bus_responder.sv | 84 ++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants for the memory bus responder: address map, STATUS bit
// positions and MMIO register offsets within the 8-word I/O window.
package mem_bus_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 7;

   localparam logic [6:0] MMIO_BASE = 7'h78;
   localparam logic [6:0] LED_ADDR  = 7'h7C;
   localparam logic [6:0] SW_ADDR   = 7'h7D;
   localparam logic [6:0] CYC_ADDR  = 7'h7E;
   localparam logic [6:0] STAT_ADDR = 7'h7F;

   localparam int STAT_ERR_BIT  = 0;
   localparam int STAT_WRAP_BIT = 1;

   // Word offsets inside the I/O window; 0..3 are reserved holes.
   typedef enum logic [2:0] {
      OFS_RSVD0 = 3'd0,
      OFS_RSVD1 = 3'd1,
      OFS_RSVD2 = 3'd2,
      OFS_RSVD3 = 3'd3,
      OFS_LED   = 3'd4,
      OFS_SW    = 3'd5,
      OFS_CYC   = 3'd6,
      OFS_STAT  = 3'd7
   } mmio_ofs_e;

endpackage

// File: rtl/mem_bus_responder_mmio_regs.sv
// Memory-mapped I/O register block: LED register, two-stage switch
// synchronizer, free-running cycle counter and sticky STATUS flags.
// Everything updates on the falling edge of CLK with synchronous reset.
module mmio_regs
   import mem_bus_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              wr_en,
   input  logic [2:0]        offset,
   input  logic [7:0]        wr_data,
   input  logic [2:0]        sw,
   output logic [DATA_W-1:0] rd_data,
   output logic [7:0]        led,
   output logic              err
);

   logic [2:0]  sw_s1;
   logic [2:0]  sw_s2;
   logic [31:0] cyc_cnt;
   logic [1:0]  status;
   logic [1:0]  status_next;

   logic led_we;
   logic cyc_we;
   logic stat_we;
   logic illegal_wr;
   logic wrap;

   // Split the single write strobe into per-register enables. Writes to
   // the reserved holes or to the read-only switch port are flagged as
   // illegal instead of touching anything.
   always_comb begin
      led_we     = 1'b0;
      cyc_we     = 1'b0;
      stat_we    = 1'b0;
      illegal_wr = 1'b0;
      if (wr_en) begin
         case (offset)
            OFS_LED:  led_we     = 1'b1;
            OFS_CYC:  cyc_we     = 1'b1;
            OFS_STAT: stat_we    = 1'b1;
            default:  illegal_wr = 1'b1;
         endcase
      end
   end

   // The counter wraps only when it actually increments; a write to the
   // counter on the same edge forces it to zero and is not a wrap. Sticky
   // sets are OR-ed in after the write-1-to-clear so a set always wins.
   always_comb begin
      wrap = !cyc_we && (cyc_cnt == 32'hFFFF_FFFF);
      status_next = status;
      status_next[STAT_ERR_BIT] = (status[STAT_ERR_BIT] & ~(stat_we & wr_data[STAT_ERR_BIT]))
                                  | illegal_wr;
      status_next[STAT_WRAP_BIT] = (status[STAT_WRAP_BIT] & ~(stat_we & wr_data[STAT_WRAP_BIT]))
                                   | wrap;
   end

   // LED register keeps only the low byte of whatever is written.
   always_ff @(negedge CLK) begin
      if (RST) begin
         led <= 8'h00;
      end else if (led_we) begin
         led <= wr_data;
      end
   end

   // Two-flop synchronizer for the asynchronous switch inputs.
   always_ff @(negedge CLK) begin
      if (RST) begin
         sw_s1 <= 3'b000;
         sw_s2 <= 3'b000;
      end else begin
         sw_s1 <= sw;
         sw_s2 <= sw_s1;
      end
   end

   // Free-running cycle counter; any write clears it regardless of data.
   always_ff @(negedge CLK) begin
      if (RST) begin
         cyc_cnt <= 32'h0000_0000;
      end else if (cyc_we) begin
         cyc_cnt <= 32'h0000_0000;
      end else begin
         cyc_cnt <= cyc_cnt + 32'd1;
      end
   end

   // Sticky status flags.
   always_ff @(negedge CLK) begin
      if (RST) begin
         status <= 2'b00;
      end else begin
         status <= status_next;
      end
   end

   assign err = status[STAT_ERR_BIT];

   // Read mux sees the current (pre-edge) register values, so a read of
   // the counter returns the value before this edge's increment.
   always_comb begin
      rd_data = '0;
      case (offset)
         OFS_LED:  rd_data = DATA_W'(led);
         OFS_SW:   rd_data = DATA_W'(sw_s2);
         OFS_CYC:  rd_data = DATA_W'(cyc_cnt);
         OFS_STAT: rd_data = DATA_W'(status);
         default:  rd_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Target side of the CPU's CS/WE/ADDR/Mem_Bus memory interface: a word RAM
// below MMIO_BASE and an 8-word I/O window above it. State changes on the
// falling edge so read data is stable for the CPU's following rising edge.
module mem_bus_responder
#(
   parameter int                ADDR_W    = mem_bus_pkg::ADDR_W_DEF,
   parameter int                DATA_W    = mem_bus_pkg::DATA_W_DEF,
   parameter logic [ADDR_W-1:0] MMIO_BASE = mem_bus_pkg::MMIO_BASE,
   parameter string             INIT_FILE = "test.txt"
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CS,
   input  logic              WE,
   input  logic [ADDR_W-1:0] ADDR,
   inout  wire  [DATA_W-1:0] Mem_Bus,
   input  logic [2:0]        SW,
   output logic [7:0]        LED,
   output logic              ERR
);

   import mem_bus_pkg::*;

   localparam int RAM_WORDS = int'(MMIO_BASE);

   logic [DATA_W-1:0] ram [0:RAM_WORDS-1];
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] mmio_rd;
   logic [2:0]        mmio_ofs;
   logic              is_ram;
   logic              ram_we;
   logic              mmio_we;
   logic              bus_drive;

   // Address decode. The I/O window is the 8 words starting at MMIO_BASE,
   // so the low three address bits relative to the base pick the register.
   always_comb begin
      is_ram   = (ADDR < MMIO_BASE);
      mmio_ofs = ADDR[2:0] - MMIO_BASE[2:0];
      ram_we   = CS && WE && is_ram && !RST;
      mmio_we  = CS && WE && !is_ram;
   end

   // RAM write port; RAM is never cleared by reset and ignores writes
   // while reset is asserted.
   always_ff @(negedge CLK) begin
      if (ram_we) begin
         ram[ADDR] <= Mem_Bus;
      end
   end

   // Read data is captured on every falling edge from the current address,
   // whether or not the initiator is selecting us, so it always reflects
   // the contents before any write landing on the same edge.
   always_ff @(negedge CLK) begin
      if (RST) begin
         rd_data <= '0;
      end else if (is_ram) begin
         rd_data <= ram[ADDR];
      end else begin
         rd_data <= mmio_rd;
      end
   end

   mmio_regs #(
      .DATA_W (DATA_W)
   ) u_mmio (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (mmio_we),
      .offset  (mmio_ofs),
      .wr_data (Mem_Bus[7:0]),
      .sw      (SW),
      .rd_data (mmio_rd),
      .led     (LED),
      .err     (ERR)
   );

   // Drive enable is purely combinational so the bus floats in the same
   // cycle the initiator raises WE or drops CS.
   assign bus_drive = CS && !WE;
   assign Mem_Bus   = bus_drive ? rd_data : 'z;

endmodule
